// File: rtl/cpu_step_clk_gen.sv
// CPU clock generator: synchronises and debounces a step button and a run switch,
// then issues single-step pulses or a free-running divided clock, counting each pulse.
module cpu_step_clk_gen #(
    parameter int DEB_CYCLES  = 500000,
    parameter int HIGH_CYCLES = 4,
    parameter int DIV_BASE    = 1000000,
    parameter int WIDTH       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             step_btn,
    input  logic             run_sw,
    input  logic [1:0]       speed_sel,
    output logic             cpu_clk,
    output logic [WIDTH-1:0] step_cnt,
    output logic             run_led,
    output logic             busy
);

    localparam int DCW = $clog2(DEB_CYCLES + 1);
    // Wide enough for DIV_BASE << 3.
    localparam int PW  = $clog2(DIV_BASE) + 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HIGH = 2'd1;
    localparam logic [1:0] ST_LOW  = 2'd2;

    logic [1:0]          raw_s;
    logic [1:0]          sync1_q, sync2_q;
    logic [1:0]          db_q, db_d;
    logic [1:0][DCW-1:0] deb_cnt_q, deb_cnt_d;
    logic                step_prev_q;
    logic                step_req_s, run_db_s, enter_high_s;
    logic [1:0]          state_q, state_d;
    logic [PW-1:0]       timer_q, timer_d;
    logic [PW-1:0]       period_q, period_d;
    logic [WIDTH-1:0]    step_cnt_q, step_cnt_d;
    logic                cpu_clk_q, busy_q;

    assign raw_s      = {run_sw, step_btn};
    assign step_req_s = db_q[0] & ~step_prev_q;
    assign run_db_s   = db_q[1];

    // Debounce: a level flips only after DEB_CYCLES consecutive differing samples.
    always_comb begin
        db_d      = db_q;
        deb_cnt_d = deb_cnt_q;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] != db_q[i]) begin
                if (deb_cnt_q[i] == DCW'(DEB_CYCLES - 1)) begin
                    db_d[i]      = sync2_q[i];
                    deb_cnt_d[i] = {DCW{1'b0}};
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + DCW'(1);
                end
            end else begin
                deb_cnt_d[i] = {DCW{1'b0}};
            end
        end
    end

    // Pulse FSM: HIGH always runs to completion; LOW can be abandoned when run drops.
    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        period_d     = period_q;
        step_cnt_d   = step_cnt_q;
        enter_high_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (run_db_s || step_req_s) begin
                    enter_high_s = 1'b1;
                end else begin
                    timer_d = {PW{1'b0}};
                end
            end
            ST_HIGH: begin
                if (timer_q == PW'(HIGH_CYCLES - 1)) begin
                    timer_d = {PW{1'b0}};
                    state_d = run_db_s ? ST_LOW : ST_IDLE;
                end else begin
                    timer_d = timer_q + PW'(1);
                end
            end
            ST_LOW: begin
                if (!run_db_s) begin
                    state_d = ST_IDLE;
                    timer_d = {PW{1'b0}};
                end else if (timer_q == period_q - PW'(HIGH_CYCLES) - PW'(1)) begin
                    enter_high_s = 1'b1;
                end else begin
                    timer_d = timer_q + PW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                timer_d = {PW{1'b0}};
            end
        endcase
        if (enter_high_s) begin
            state_d    = ST_HIGH;
            timer_d    = {PW{1'b0}};
            period_d   = PW'(DIV_BASE) << speed_sel;
            step_cnt_d = step_cnt_q + WIDTH'(1);
        end else begin
            step_cnt_d = step_cnt_q;
        end
    end

    // State, synchronisers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= 2'b00;
            sync2_q     <= 2'b00;
            db_q        <= 2'b00;
            deb_cnt_q   <= '0;
            step_prev_q <= 1'b0;
            state_q     <= ST_IDLE;
            timer_q     <= {PW{1'b0}};
            period_q    <= {PW{1'b0}};
            step_cnt_q  <= {WIDTH{1'b0}};
            cpu_clk_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            sync1_q     <= raw_s;
            sync2_q     <= sync1_q;
            db_q        <= db_d;
            deb_cnt_q   <= deb_cnt_d;
            step_prev_q <= db_q[0];
            state_q     <= state_d;
            timer_q     <= timer_d;
            period_q    <= period_d;
            step_cnt_q  <= step_cnt_d;
            cpu_clk_q   <= (state_d == ST_HIGH);
            busy_q      <= (state_d != ST_IDLE);
        end
    end

    assign cpu_clk  = cpu_clk_q;
    assign step_cnt = step_cnt_q;
    assign run_led  = db_q[1];
    assign busy     = busy_q;

endmodule

// File: doc/cpu_step_clk_gen.md
Name: cpu_step_clk_gen

Overview:
- Upstream stage of the CPU display top level: derives the CPU clock from the board clock.
- Operator controls: a raw push button (single step) and a raw run switch (free run).
- Synchronises and debounces both controls, then generates either one CPU clock pulse per button press or a continuous divided clock with selectable speed.
- Also counts issued CPU clock pulses for display and indicates run status.

Parameters:
- DEB_CYCLES, 500000: consecutive stable board cycles required before a debounced level changes; >=2.
- HIGH_CYCLES, 4: board cycles cpu_clk stays high per pulse; >=1.
- DIV_BASE, 1000000: free-run period in board cycles at speed_sel=0; must be >2*HIGH_CYCLES.
- WIDTH, 8: step counter width.

Ports:
- clk, input, 1: board clock; all state on rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- step_btn, input, 1: raw, asynchronous, bouncy step button; active high.
- run_sw, input, 1: raw, asynchronous run switch; 1 = free run.
- speed_sel, input, 2: free-run period select; period = DIV_BASE << speed_sel.
- cpu_clk, output, 1: registered generated CPU clock.
- step_cnt, output, WIDTH: number of cpu_clk rising edges issued, modulo 2^WIDTH.
- run_led, output, 1: debounced run_sw level.
- busy, output, 1: high whenever the FSM is not in IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - Synchroniser flops, debounced levels, debounce counters and edge-detect flop all 0.
  - FSM = IDLE; cpu_clk = 0; step_cnt = 0; run_led = 0; busy = 0.
- Synchronisation: two-flop synchroniser per raw input.
- Debounce, per input:
  - Counter runs while the synchronised value differs from the debounced level; cleared whenever they are equal.
  - Debounced level flips on the edge where it has differed for DEB_CYCLES consecutive edges.
  - Glitches shorter than DEB_CYCLES cycles never reach the debounced level.
- Step request: one-cycle pulse on the rising edge of the debounced step level (debounced=1, previous=0).
- Period register: latches DIV_BASE << speed_sel on every HIGH entry; changes to speed_sel take effect from the next pulse.
- FSM states IDLE / HIGH / LOW:
  - IDLE -> HIGH: run_db=1 or step request. Run has priority; step+run in the same cycle yields a single entry.
  - HIGH: lasts exactly HIGH_CYCLES cycles, then -> LOW if run_db=1, else -> IDLE.
  - LOW: lasts period-HIGH_CYCLES cycles, then -> HIGH. If run_db falls during LOW -> IDLE on the next edge; cpu_clk is already low, so no runt pulse.
  - run_db falling during HIGH: HIGH still completes its full HIGH_CYCLES, then -> IDLE. Pulses are never truncated.
- Step requests arriving outside IDLE are dropped, not queued.
- cpu_clk is a registered output, equal to 1 exactly while in HIGH. A step therefore produces exactly HIGH_CYCLES high cycles.
- step_cnt increments on each HIGH entry and wraps from 2^WIDTH-1 to 0.
- Latency: raw input changes between edges N and N+1 and is held stable afterwards.
  - Debounced level changes at edge N+2+DEB_CYCLES.
  - cpu_clk rises at edge N+3+DEB_CYCLES.
  - step_cnt updates on the same edge as cpu_clk.
- Free-run period: cpu_clk rising edges are exactly DIV_BASE << speed_sel board cycles apart.
- Mid-operation reset forces cpu_clk low immediately (asynchronous); there is no completion of the pulse in progress.

Test Plan (DEB_CYCLES=4, HIGH_CYCLES=2, DIV_BASE=8 overridden):
- Clean single press: step_btn high 20 cycles, run_sw=0 -> exactly one cpu_clk pulse, 2 cycles wide, rising at edge N+7; step_cnt 0->1; busy high for 2 cycles.
- Bouncy press: step_btn toggles every 2 cycles for 10 cycles, then held high -> no pulse during bounce, exactly one pulse after stabilising; a 3-cycle glitch alone -> no pulse.
- Free run: run_sw=1, speed_sel=0 -> cpu_clk rising edges every 8 cycles, 2 high / 6 low; speed_sel=2 mid-run -> from the next pulse, period becomes 32.
- Run switched off during HIGH -> pulse completes its 2 cycles, then IDLE. Run switched off during LOW -> IDLE, no further pulse, no runt.
- step_cnt wrap: 256 steps from reset -> step_cnt returns to 0. A press during free-run LOW -> no extra pulse; step_cnt advances only per period.
- Async reset asserted mid-HIGH -> cpu_clk=0 and step_cnt=0 before the next clk edge. After release, no pulse until a new debounced press.
